// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores shared access to one single-port
// synchronous data RAM, including sequencing of the RAM's one-cycle read latency.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_gnt,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [NUM_CORES-1:0]          core_err,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [1:0]                    fsm_state
);

    // Handshake: a core holds req/we/addr/wdata stable until its one-cycle gnt;
    // dropping req earlier withdraws it, and a read answers with a one-cycle rvalid.

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RDRET  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  idx_p;
    int                idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic              take;

    logic [PTR_W-1:0]  lat_core;
    logic              lat_we;
    logic              lat_oor;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;

    // First requester above the last winner, wrapping; the lowest offset wins.
    always_comb begin
        win   = rr_ptr;
        idx   = 0;
        idx_p = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            idx_p = PTR_W'(idx);
            if (core_req[idx_p]) win = idx_p;
        end
    end

    assign sel_addr  = core_addr[win*ADDR_W +: ADDR_W];
    assign sel_wdata = core_wdata[win*DATA_W +: DATA_W];
    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH);
    assign take      = (state == IDLE) && (|core_req);

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|core_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? IDLE : RDWAIT;
            RDWAIT:  state_nxt = RDRET;
            RDRET:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; all strobes decode from state and latched request only.
    always_comb begin
        core_gnt    = '0;
        core_err    = '0;
        core_rvalid = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (state)
            ISSUE: begin
                core_gnt[lat_core] = 1'b1;
                core_err[lat_core] = lat_oor;
                mem_en             = !lat_oor;
                mem_we             = !lat_oor && lat_we;
            end
            RDRET:   core_rvalid[lat_core] = 1'b1;
            default: ;
        endcase
    end

    // Request capture and read-data register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= PTR_W'(NUM_CORES - 1);
            lat_core  <= '0;
            lat_we    <= 1'b0;
            lat_oor   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (take) begin
                rr_ptr    <= win;
                lat_core  <= win;
                lat_we    <= core_we[win];
                lat_oor   <= sel_oor;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            // Out-of-range reads still pass through RDWAIT so read latency is uniform.
            if (state == RDWAIT) begin
                rdata_q <= lat_oor ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign core_rdata = rdata_q;
    assign fsm_state  = state;

    a_gnt_onehot: assert property (@(posedge clock) disable iff (!rst_n)
        $onehot0(core_gnt));
    a_rvalid_onehot: assert property (@(posedge clock) disable iff (!rst_n)
        $onehot0(core_rvalid));
    a_err_with_gnt: assert property (@(posedge clock) disable iff (!rst_n)
        (core_err & ~core_gnt) == '0);
    a_mem_with_gnt: assert property (@(posedge clock) disable iff (!rst_n)
        mem_en |-> (|core_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drivers push expected grants/returns into a
// queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_arbiter;

    localparam int NC    = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 128;
    localparam int W     = 48;

    logic              clock = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_gnt;
    logic [NC-1:0]     core_rvalid;
    logic [DW-1:0]     core_rdata;
    logic [NC-1:0]     core_err;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [1:0]        fsm_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_h;
    logic [3:0]   mon_oh;
    logic [DW-1:0] ram [0:255];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    dmem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    // Single-port RAM with one-cycle read latency
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    // Entry: [47:32] cycle, [31] 1=rvalid, [30:28] core, [27] err, [26] mem_en,
    // [25] mem_we, [23:16] addr, [15:0] wdata (grant) or rdata (return).
    function automatic logic [W-1:0] mk_gnt(int c, int core, bit err, bit en, bit we,
                                            logic [7:0] addr, logic [15:0] data);
        logic [W-1:0] e;
        e = '0;
        e[47:32] = c[15:0];
        e[30:28] = core[2:0];
        e[27]    = err;
        e[26]    = en;
        e[25]    = we;
        e[23:16] = addr;
        e[15:0]  = data;
        return e;
    endfunction

    function automatic logic [W-1:0] mk_rv(int c, int core, logic [15:0] data);
        logic [W-1:0] e;
        e = '0;
        e[47:32] = c[15:0];
        e[31]    = 1'b1;
        e[30:28] = core[2:0];
        e[15:0]  = data;
        return e;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with no matching expectation at cycle %0d", name, act, cyc);
    endfunction

    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0][47:32] < cyc[15:0]) begin
            mon_h = exp_q.pop_front();
            flag(mon_h[31] ? "missing_rvalid" : "missing_gnt", {16'h0, mon_h[47:32]});
        end
        if (|core_gnt) begin
            if (exp_q.size() > 0 && exp_q[0][47:32] == cyc[15:0] && !exp_q[0][31]) begin
                mon_h  = exp_q.pop_front();
                mon_oh = 4'b0001 << mon_h[30:28];
                chk("gnt", {28'h0, core_gnt}, {28'h0, mon_oh});
                chk("err", {28'h0, core_err}, mon_h[27] ? {28'h0, mon_oh} : 32'h0);
                chk("mem_en", {31'h0, mem_en}, {31'h0, mon_h[26]});
                chk("mem_we", {31'h0, mem_we}, {31'h0, mon_h[25]});
                if (mon_h[26]) begin
                    chk("mem_addr", {24'h0, mem_addr}, {24'h0, mon_h[23:16]});
                    chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, mon_h[15:0]});
                end
            end else begin
                flag("unexpected_gnt", {28'h0, core_gnt});
            end
        end else begin
            if (|core_err) flag("err_without_gnt", {28'h0, core_err});
            if (mem_en)    flag("mem_en_without_gnt", {31'h0, mem_en});
        end
        if (|core_rvalid) begin
            if (exp_q.size() > 0 && exp_q[0][47:32] == cyc[15:0] && exp_q[0][31]) begin
                mon_h  = exp_q.pop_front();
                mon_oh = 4'b0001 << mon_h[30:28];
                chk("rvalid", {28'h0, core_rvalid}, {28'h0, mon_oh});
                chk("rdata", {16'h0, core_rdata}, {16'h0, mon_h[15:0]});
            end else begin
                flag("unexpected_rvalid", {28'h0, core_rvalid});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_req(int c, bit we, logic [7:0] addr, logic [15:0] wd);
        core_req[c]            = 1'b1;
        core_we[c]             = we;
        core_addr[c*AW +: AW]  = addr;
        core_wdata[c*DW +: DW] = wd;
    endtask

    task automatic clr_req(int c);
        core_req[c] = 1'b0;
    endtask

    // Lone request from IDLE: gnt at T+1, read return at T+3.
    task automatic access(int c, bit we, logic [7:0] addr, logic [15:0] wd,
                          bit oor, logic [15:0] rd);
        set_req(c, we, addr, wd);
        exp_q.push_back(mk_gnt(cyc + 1, c, oor, !oor, we && !oor, addr, wd));
        if (!we) exp_q.push_back(mk_rv(cyc + 3, c, oor ? 16'h0000 : rd));
        step(1);
        clr_req(c);
        step(3);
    endtask

    function automatic void check_idle(string tag);
        chk({tag, "_gnt"},    {28'h0, core_gnt},    32'h0);
        chk({tag, "_rvalid"}, {28'h0, core_rvalid}, 32'h0);
        chk({tag, "_err"},    {28'h0, core_err},    32'h0);
        chk({tag, "_rdata"},  {16'h0, core_rdata},  32'h0);
        chk({tag, "_mem_en"}, {31'h0, mem_en},      32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we},      32'h0);
        chk({tag, "_maddr"},  {24'h0, mem_addr},    32'h0);
        chk({tag, "_mwdata"}, {16'h0, mem_wdata},   32'h0);
        chk({tag, "_state"},  {30'h0, fsm_state},   32'h0);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst_n      = 1'b0;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        step(2);
        check_idle("reset");
        rst_n = 1'b1;
        step(1);

        // Round robin: all four hold write requests, order 0,1,2,3,0
        t = cyc;
        for (int i = 0; i < NC; i++) set_req(i, 1'b1, 8'h40 + 8'(i), 16'hA000 + 16'(i));
        for (int k = 0; k < 5; k++)
            exp_q.push_back(mk_gnt(t + 1 + 2*k, k % NC, 1'b0, 1'b1, 1'b1,
                                   8'h40 + 8'(k % NC), 16'hA000 + 16'(k % NC)));
        step(9);
        core_req = '0;
        step(2);

        // Single write, single read, readbacks, in-range boundary
        access(2, 1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0000);
        access(1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF);
        access(0, 1'b0, 8'h42, 16'h0000, 1'b0, 16'hA002);
        access(1, 1'b1, 8'h7F, 16'h1357, 1'b0, 16'h0000);
        access(2, 1'b0, 8'h7F, 16'h0000, 1'b0, 16'h1357);

        // Out of range: read at 0x90, write at first illegal address 0x80
        access(3, 1'b0, 8'h90, 16'h0000, 1'b1, 16'h0000);
        access(0, 1'b1, 8'h80, 16'hDEAD, 1'b1, 16'h0000);

        // Withdrawal: core 2 requests only while core 0's read is in flight
        t = cyc;
        set_req(0, 1'b0, 8'h10, 16'h0000);
        exp_q.push_back(mk_gnt(t + 1, 0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000));
        exp_q.push_back(mk_rv(t + 3, 0, 16'hBEEF));
        step(1);
        clr_req(0);
        set_req(2, 1'b1, 8'h30, 16'h5555);
        step(2);
        clr_req(2);
        step(3);

        // Reset while a read waits on the RAM
        t = cyc;
        set_req(1, 1'b0, 8'h10, 16'h0000);
        exp_q.push_back(mk_gnt(t + 1, 1, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000));
        step(1);
        clr_req(1);
        step(1);
        chk("state_rdwait", {30'h0, fsm_state}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_idle("midread_reset");
        step(2);
        rst_n = 1'b1;
        step(4);

        // Cores 0 and 3 together after reset: core 0 first
        t = cyc;
        set_req(0, 1'b1, 8'h20, 16'h1111);
        set_req(3, 1'b1, 8'h21, 16'h2222);
        exp_q.push_back(mk_gnt(t + 1, 0, 1'b0, 1'b1, 1'b1, 8'h20, 16'h1111));
        exp_q.push_back(mk_gnt(t + 3, 3, 1'b0, 1'b1, 1'b1, 8'h21, 16'h2222));
        step(1);
        clr_req(0);
        step(2);
        clr_req(3);
        step(3);
        access(0, 1'b0, 8'h21, 16'h0000, 1'b0, 16'h2222);

        step(2);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
